// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } pisoState_t;

   function automatic int countWidth(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bits-remaining down-counter: loads WIDTH, counts down, flags zero.
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CW = countWidth(WIDTH)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Clear,
   input  logic          Load,
   input  logic          Dec,
   output logic [CW-1:0] Count,
   output logic          Zero
);

   assign Zero = (Count == '0);

   // Saturating at zero keeps the count within 0..WIDTH.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Count <= '0;
      end else if (Clear) begin
         Count <= '0;
      end else if (Load) begin
         Count <= CW'(WIDTH);
      end else if (Dec && !Zero) begin
         Count <= Count - CW'(1);
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shift register with load/shift handshake,
// back-to-back word chaining, abort and a per-word Done pulse.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   localparam int CW = countWidth(WIDTH)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Abort,
   input  logic             LoadValid,
   output logic             LoadReady,
   input  logic [WIDTH-1:0] ParallelIn,
   input  logic             ShiftEn,
   input  logic             ShiftIn,
   output logic             ShiftOut,
   output logic             OutValid,
   output logic             Done,
   output logic [CW-1:0]    BitsLeft,
   output logic [WIDTH-1:0] RegContent
);

   pisoState_t       state;
   pisoState_t       nextState;
   logic [WIDTH-1:0] shiftReg;
   logic [WIDTH-1:0] shifted;
   logic             doneReg;
   logic             cntZero;
   logic             shiftFire;
   logic             lastBit;
   logic             loadFire;

   assign shiftFire = (state == SHIFT) && ShiftEn && !cntZero;
   assign lastBit   = shiftFire && (BitsLeft == CW'(1));
   assign loadFire  = LoadValid && LoadReady && !Abort;

   assign shifted = (MSB_FIRST != 0)
                  ? {shiftReg[WIDTH-2:0], ShiftIn}
                  : {ShiftIn, shiftReg[WIDTH-1:1]};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Abort overrides everything; a load on the last bit keeps SHIFT.
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (loadFire) nextState = SHIFT;
         end
         SHIFT: begin
            if (lastBit && !loadFire) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
      if (Abort) nextState = IDLE;
   end

   always_comb begin
      LoadReady = 1'b0;
      OutValid  = 1'b0;
      unique case (state)
         IDLE: begin
            LoadReady = 1'b1;
         end
         SHIFT: begin
            OutValid  = 1'b1;
            LoadReady = lastBit;
         end
         default: begin
            LoadReady = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         shiftReg <= '0;
         doneReg  <= 1'b0;
      end else begin
         doneReg <= lastBit && !Abort;
         if (Abort) begin
            shiftReg <= '0;
         end else if (loadFire) begin
            shiftReg <= ParallelIn;
         end else if (shiftFire) begin
            shiftReg <= shifted;
         end
      end
   end

   piso_bit_counter #(
      .WIDTH (WIDTH)
   ) uCounter (
      .Clk   (Clk),
      .Reset (Reset),
      .Clear (Abort),
      .Load  (loadFire),
      .Dec   (shiftFire),
      .Count (BitsLeft),
      .Zero  (cntZero)
   );

   assign ShiftOut   = (MSB_FIRST != 0) ? shiftReg[WIDTH-1] : shiftReg[0];
   assign Done       = doneReg;
   assign RegContent = shiftReg;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances side by side.
module tb_piso_serializer;

   localparam int W = 8;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Abort;
   logic       LoadValid;
   logic [7:0] ParallelIn;
   logic       ShiftEn;
   logic       ShiftIn;

   logic       lrA, soA, ovA, doneA;
   logic [3:0] blA;
   logic [7:0] rcA;
   logic       lrB, soB, ovB, doneB;
   logic [3:0] blB;
   logic [7:0] rcB;

   int checks = 0;
   int errors = 0;

   logic [7:0] mReg[2];
   int         mCnt[2];
   logic       mDone[2];

   typedef struct {
      logic       lv;
      logic [7:0] pin;
      logic       se;
      logic       lr;
      logic       soA;
      logic       soB;
      logic       done;
      logic [3:0] bl;
      logic [7:0] rcA;
      logic [7:0] rcB;
   } vec_t;

   vec_t tbl[11];

   always #5 Clk = ~Clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dutA (
      .Clk(Clk), .Reset(Reset), .Abort(Abort),
      .LoadValid(LoadValid), .LoadReady(lrA),
      .ParallelIn(ParallelIn), .ShiftEn(ShiftEn),
      .ShiftIn(ShiftIn), .ShiftOut(soA), .OutValid(ovA),
      .Done(doneA), .BitsLeft(blA), .RegContent(rcA)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dutB (
      .Clk(Clk), .Reset(Reset), .Abort(Abort),
      .LoadValid(LoadValid), .LoadReady(lrB),
      .ParallelIn(ParallelIn), .ShiftEn(ShiftEn),
      .ShiftIn(ShiftIn), .ShiftOut(soB), .OutValid(ovB),
      .Done(doneB), .BitsLeft(blB), .RegContent(rcB)
   );

   function automatic vec_t mk(
      input logic lv, input logic [7:0] pin, input logic se,
      input logic lr, input logic sa, input logic sb,
      input logic dn, input logic [3:0] bl,
      input logic [7:0] ra, input logic [7:0] rb);
      vec_t v;
      v.lv = lv; v.pin = pin; v.se = se; v.lr = lr;
      v.soA = sa; v.soB = sb; v.done = dn; v.bl = bl;
      v.rcA = ra; v.rcB = rb;
      return v;
   endfunction

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         mReg[k]  = '0;
         mCnt[k]  = 0;
         mDone[k] = 1'b0;
      end
   endtask

   // Expected {LoadReady, ShiftOut, OutValid, Done, BitsLeft, RegContent}
   function automatic logic [15:0] expVec(input int k);
      logic lr;
      logic so;
      lr = (mCnt[k] == 0) || (ShiftEn && mCnt[k] == 1);
      so = (k == 0) ? mReg[k][7] : mReg[k][0];
      return {lr, so, mCnt[k] > 0, mDone[k], 4'(mCnt[k]), mReg[k]};
   endfunction

   task automatic modelEdge();
      for (int k = 0; k < 2; k++) begin
         int  r;
         bit  fire;
         bit  last;
         bit  ld;
         fire = (mCnt[k] > 0) && ShiftEn;
         last = fire && (mCnt[k] == 1);
         ld   = LoadValid && !Abort && ((mCnt[k] == 0) || last);
         if (Reset || Abort) begin
            mReg[k]  = '0;
            mCnt[k]  = 0;
            mDone[k] = 1'b0;
         end else begin
            mDone[k] = last;
            if (ld) begin
               mReg[k] = ParallelIn;
               mCnt[k] = W;
            end else if (fire) begin
               r = int'(mReg[k]);
               if (k == 0) r = (r * 2 + int'(ShiftIn)) % 256;
               else        r = r / 2 + 128 * int'(ShiftIn);
               mReg[k] = 8'(r);
               mCnt[k] = mCnt[k] - 1;
            end
         end
      end
   endtask

   task automatic drive(input logic a, input logic lv,
                        input logic [7:0] pin,
                        input logic se, input logic si);
      @(negedge Clk);
      Reset      = 1'b0;
      Abort      = a;
      LoadValid  = lv;
      ParallelIn = pin;
      ShiftEn    = se;
      ShiftIn    = si;
      #1;
      check("dutA", {16'h0, lrA, soA, ovA, doneA, blA, rcA}, {16'h0, expVec(0)});
      check("dutB", {16'h0, lrB, soB, ovB, doneB, blB, rcB}, {16'h0, expVec(1)});
   endtask

   task automatic edgeStep();
      @(posedge Clk);
      modelEdge();
   endtask

   task automatic step(input logic a, input logic lv,
                       input logic [7:0] pin,
                       input logic se, input logic si);
      drive(a, lv, pin, se, si);
      edgeStep();
   endtask

   initial begin
      logic [7:0]  colA;
      logic [7:0]  colB;
      logic [15:0] col16;
      int          n;
      int          dones;
      bit          ovDrop;
      bit          pat[6];

      Reset = 1'b1; Abort = 1'b0; LoadValid = 1'b0;
      ParallelIn = '0; ShiftEn = 1'b0; ShiftIn = 1'b0;
      modelReset();

      tbl[0]  = mk(1, 8'h0F, 0, 1, 0, 0, 0, 4'd0, 8'h00, 8'h00);
      tbl[1]  = mk(0, 8'h00, 1, 0, 0, 1, 0, 4'd8, 8'h0F, 8'h0F);
      tbl[2]  = mk(0, 8'h00, 1, 0, 0, 1, 0, 4'd7, 8'h1E, 8'h07);
      tbl[3]  = mk(0, 8'h00, 1, 0, 0, 1, 0, 4'd6, 8'h3C, 8'h03);
      tbl[4]  = mk(0, 8'h00, 1, 0, 0, 1, 0, 4'd5, 8'h78, 8'h01);
      tbl[5]  = mk(0, 8'h00, 1, 0, 1, 0, 0, 4'd4, 8'hF0, 8'h00);
      tbl[6]  = mk(0, 8'h00, 1, 0, 1, 0, 0, 4'd3, 8'hE0, 8'h00);
      tbl[7]  = mk(0, 8'h00, 1, 0, 1, 0, 0, 4'd2, 8'hC0, 8'h00);
      tbl[8]  = mk(0, 8'h00, 1, 1, 1, 0, 0, 4'd1, 8'h80, 8'h00);
      tbl[9]  = mk(0, 8'h00, 0, 1, 0, 0, 1, 4'd0, 8'h00, 8'h00);
      tbl[10] = mk(0, 8'h00, 0, 1, 0, 0, 0, 4'd0, 8'h00, 8'h00);

      #3;
      check("resetState", {16'h0, lrA, soA, ovA, doneA, blA, rcA},
            {16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00});

      // Table: 0x0F loaded on the first edge after reset release
      for (int i = 0; i < 11; i++) begin
         drive(1'b0, tbl[i].lv, tbl[i].pin, tbl[i].se, 1'b0);
         check($sformatf("tbl%0d", i),
               {8'h0, lrA, soA, soB, doneA, blA, rcA, rcB},
               {8'h0, tbl[i].lr, tbl[i].soA, tbl[i].soB, tbl[i].done,
                tbl[i].bl, tbl[i].rcA, tbl[i].rcB});
         edgeStep();
      end

      // Fill with ones
      step(0, 1, 8'h0F, 0, 1);
      for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1, 1);
      drive(0, 0, 8'h00, 0, 0);
      check("fillOnes", {16'h0, rcA, rcB}, {16'h0, 8'hFF, 8'hFF});
      edgeStep();

      // Stalled shifting with pattern 1,0,0,1,1,0
      pat = '{1, 0, 0, 1, 1, 0};
      step(0, 1, 8'hA5, 0, 0);
      n = 0; colA = '0; colB = '0;
      for (int i = 0; i < 40 && n < 8; i++) begin
         drive(0, 0, 8'h00, pat[i % 6], 0);
         if (pat[i % 6]) begin
            colA[7 - n] = soA;
            colB[n]     = soB;
            n++;
         end
         edgeStep();
      end
      check("stallBitsA", {24'h0, colA}, {24'h0, 8'hA5});
      check("stallBitsB", {24'h0, colB}, {24'h0, 8'hA5});
      step(0, 0, 8'h00, 0, 0);

      // Back-to-back words with LoadValid held
      step(0, 1, 8'hA5, 0, 0);
      dones = 0; ovDrop = 0; col16 = '0;
      for (int i = 0; i < 17; i++) begin
         drive(0, i < 8, 8'h3C, i < 16, 0);
         if (i < 16) begin
            col16[15 - i] = soA;
            if (!ovA) ovDrop = 1;
         end
         if (doneA) dones++;
         edgeStep();
      end
      check("b2bBits", {16'h0, col16}, {16'h0, 16'hA53C});
      check("b2bDones", dones, 2);
      check("b2bOutValid", {31'h0, ovDrop}, 32'h0);
      step(0, 0, 8'h00, 0, 0);

      // Asynchronous reset mid-word
      step(0, 1, 8'hA5, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0);
      #2;
      Reset = 1'b1;
      modelReset();
      #1;
      check("asyncRst", {16'h0, lrA, soA, ovA, doneA, blA, rcA},
            {16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00});
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 0);

      // Abort wins over load; mid-word loads ignored
      step(0, 1, 8'hA5, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 8'hFF, 1, 0);
      step(1, 1, 8'h5A, 1, 0);
      drive(0, 0, 8'h00, 0, 0);
      check("abort", {16'h0, ovA, doneA, blA, rcA}, 32'h0);
      edgeStep();
      step(0, 0, 8'h00, 0, 0);

      // Randomised traffic against the model
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 39) == 0,
              $urandom_range(0, 2) != 0,
              8'($urandom),
              $urandom_range(0, 3) != 0,
              1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
